// File: rtl/ether_tx.sv
// ether_tx: RMII transmit MAC. It frames upstream bytes as preamble + SFD + payload (+ optional pad) + FCS, then inserts the inter-packet gap.
// Latency: txen/txd are registered and aligned with the FSM state. The first preamble dibit appears one cycle after axiiv is seen in IDLE.
// Backpressure: axiir is high only on the cycle a new byte is needed. If axiiv is low on that cycle, the frame aborts with an underflow pulse.
//
// Ports:
//   clk        50 MHz RMII reference clock (the only clock)
//   rst        synchronous active-high reset
//   axiiv/axiid/axiil/axiir  byte stream in (valid, data, last, ready)
//   txen/txd   RMII transmit enable and dibit (txd[0] is the earlier bit)
//   busy       high whenever the FSM is not in IDLE
//   underflow  one-cycle pulse when a frame is aborted for lack of data
// Build option: define ETHER_TX_PAD_EN to zero-pad short frames up to MIN_PAYLOAD bytes.
module ether_tx #(
  parameter int IPG_CYCLES  = 48,
  parameter int MIN_PAYLOAD = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       axiiv,
  input  logic [7:0] axiid,
  input  logic       axiil,
  output logic       axiir,
  output logic       txen,
  output logic [1:0] txd,
  output logic       busy,
  output logic       underflow
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    DATA     = 3'd2,
`ifdef ETHER_TX_PAD_EN
    PAD      = 3'd3,
`endif
    FCS      = 3'd4,
    IPG      = 3'd5
  } state_t;

  localparam logic [15:0] IPG_LAST = 16'(IPG_CYCLES - 1);
  localparam logic [10:0] MIN_LEN  = 11'(MIN_PAYLOAD);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [5:0]  sh_q, sh_d;      // remaining three dibits of the byte on the wire
  logic        last_q, last_d;  // byte on the wire was flagged last
  logic [10:0] len_q, len_d;    // bytes sent so far, saturating
  logic [31:0] crc_q, crc_d;
  logic        txen_q, txen_d;
  logic [1:0]  txd_q, txd_d;
  logic [10:0] len_inc;
  logic        take;
  logic        fcs_start;

  // Reflected CRC-32, two bits per call, earlier bit (d[0]) first.
  function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 2; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  // Ready depends only on state and counter, never on axiiv.
  assign axiir = ((state_q == PREAMBLE) && (cnt_q == 16'd31)) ||
                 ((state_q == DATA) && (cnt_q == 16'd3) && !last_q);
  assign take      = axiiv & axiir;
  assign underflow = axiir & ~axiiv;
  assign busy      = (state_q != IDLE);
  assign txen      = txen_q;
  assign txd       = txd_q;
  assign len_inc   = (len_q == 11'h7FF) ? len_q : len_q + 11'd1;

`ifndef ETHER_TX_PAD_EN
  logic len_unused;
  assign len_unused = ^{len_q, MIN_LEN};
`endif

  // txen_d/txd_d describe the dibit for the state being entered, so the
  // registered outputs line up with state_q.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    last_d    = last_q;
    len_d     = len_q;
    crc_d     = crc_q;
    txen_d    = 1'b0;
    txd_d     = 2'b00;
    fcs_start = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (axiiv) begin
          state_d = PREAMBLE;
          cnt_d   = '0;
          txen_d  = 1'b1;
          txd_d   = 2'b01;
          crc_d   = '1;
          len_d   = '0;
        end
      end
      PREAMBLE: begin
        if (cnt_q != 16'd31) begin
          cnt_d  = cnt_q + 16'd1;
          txen_d = 1'b1;
          txd_d  = (cnt_q == 16'd30) ? 2'b11 : 2'b01;
        end else if (!axiiv) begin
          state_d = IPG;
          cnt_d   = '0;
        end
      end
      DATA: begin
        if (cnt_q != 16'd3) begin
          cnt_d  = cnt_q + 16'd1;
          txen_d = 1'b1;
          txd_d  = sh_q[1:0];
          sh_d   = {2'b00, sh_q[5:2]};
          crc_d  = crc_dibit(crc_q, sh_q[1:0]);
        end else if (last_q) begin
`ifdef ETHER_TX_PAD_EN
          if (len_q < MIN_LEN) begin
            state_d = PAD;
            cnt_d   = '0;
            txen_d  = 1'b1;
            crc_d   = crc_dibit(crc_q, 2'b00);
          end else begin
            fcs_start = 1'b1;
          end
`else
          fcs_start = 1'b1;
`endif
        end else if (!axiiv) begin
          state_d = IPG;
          cnt_d   = '0;
        end
      end
`ifdef ETHER_TX_PAD_EN
      PAD: begin
        if (cnt_q != 16'd3) begin
          cnt_d  = cnt_q + 16'd1;
          txen_d = 1'b1;
          crc_d  = crc_dibit(crc_q, 2'b00);
        end else begin
          len_d = len_inc;
          if (len_inc >= MIN_LEN) begin
            fcs_start = 1'b1;
          end else begin
            cnt_d  = '0;
            txen_d = 1'b1;
            crc_d  = crc_dibit(crc_q, 2'b00);
          end
        end
      end
`endif
      FCS: begin
        // crc_q shifts right each cycle so bit 0 is always next on the wire.
        if (cnt_q != 16'd15) begin
          cnt_d  = cnt_q + 16'd1;
          txen_d = 1'b1;
          txd_d  = ~crc_q[1:0];
          crc_d  = crc_q >> 2;
        end else begin
          state_d = IPG;
          cnt_d   = '0;
        end
      end
      IPG: begin
        if (cnt_q == IPG_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (take) begin
      state_d = DATA;
      cnt_d   = '0;
      txen_d  = 1'b1;
      txd_d   = axiid[1:0];
      sh_d    = axiid[7:2];
      last_d  = axiil;
      len_d   = len_inc;
      crc_d   = crc_dibit(crc_q, axiid[1:0]);
    end

    // By the last DATA/PAD cycle every payload dibit is already folded into crc_q.
    if (fcs_start) begin
      state_d = FCS;
      cnt_d   = '0;
      txen_d  = 1'b1;
      txd_d   = ~crc_q[1:0];
      crc_d   = crc_q >> 2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      last_q  <= 1'b0;
      len_q   <= '0;
      crc_q   <= '1;
      txen_q  <= 1'b0;
      txd_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      last_q  <= last_d;
      len_q   <= len_d;
      crc_q   <= crc_d;
      txen_q  <= txen_d;
      txd_q   <= txd_d;
    end
  end

endmodule

// File: tb/tb_ether_tx.sv
// tb_ether_tx: drives byte streams into ether_tx and compares the RMII output against a byte-level frame model.
// Latency: outputs are sampled on the falling edge of clk.
// Backpressure: the driver presents a byte whenever it has one and advances on axiiv & axiir.
module tb_ether_tx;
  localparam int IPG  = 48;
  localparam int MINP = 60;

  logic       clk = 1'b0;
  logic       rst;
  logic       axiiv, axiil, axiir, txen, busy, underflow;
  logic [7:0] axiid;
  logic [1:0] txd;

  always #10 clk = ~clk;

  ether_tx #(.IPG_CYCLES(IPG), .MIN_PAYLOAD(MINP)) dut (
    .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid), .axiil(axiil), .axiir(axiir),
    .txen(txen), .txd(txd), .busy(busy), .underflow(underflow)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct { logic [7:0] d; logic l; } sbyte_t;
  sbyte_t     stream[$];
  int         drop_at;
  logic [1:0] cap[$];
  int         runs[$];
  int         ipgs[$];
  int         gaps[$];
  int         uf_cnt, idle_viol, uf_txen_bad;
  logic [1:0] exp_d[$];
  int         exp_runs[$];
  int         exp_uf;
  logic [7:0] pay_q[$];

  task automatic push_frame(input int len, input int mode);
    sbyte_t s;
    for (int i = 0; i < len; i++) begin
      s.d = (mode == 1) ? 8'(8'h31 + i) : (mode == 2) ? 8'hA5 : 8'($urandom);
      s.l = (i == len - 1);
      stream.push_back(s);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int k = 0; k < 4; k++) exp_d.push_back(b[2*k +: 2]);
  endtask

  // Standard bytewise reflected CRC-32; the transmitted FCS is its complement.
  function automatic logic [31:0] fcs_of_pay();
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (pay_q[n]) begin
      c ^= {24'b0, pay_q[n]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // Expected wire image: each frame is 7x55, D5, payload (padded), FCS, all LSB first.
  task automatic build_expect();
    int i, j, base;
    bit cut;
    logic [31:0] f;
    exp_d.delete(); exp_runs.delete(); exp_uf = 0;
    i = 0;
    while (i < stream.size()) begin
      base = exp_d.size();
      pay_q.delete();
      for (int k = 0; k < 7; k++) push_byte(8'h55);
      push_byte(8'hD5);
      cut = 0;
      j = i;
      while (1) begin
        if (j == drop_at) begin cut = 1; break; end
        pay_q.push_back(stream[j].d);
        push_byte(stream[j].d);
        if (stream[j].l || j == stream.size() - 1) break;
        j++;
      end
      if (cut) begin
        exp_uf = 1;
        exp_runs.push_back(exp_d.size() - base);
        break;
      end
`ifdef ETHER_TX_PAD_EN
      while (pay_q.size() < MINP) begin pay_q.push_back(8'h00); push_byte(8'h00); end
`endif
      f = fcs_of_pay();
      for (int k = 0; k < 4; k++) push_byte(f[8*k +: 8]);
      exp_runs.push_back(exp_d.size() - base);
      i = j + 1;
    end
  endtask

  task automatic run_stream();
    int idx = 0, gap = 0, cyc = 0;
    bit xfer = 0, seen = 0, done = 0, prev_txen = 0, uf_prev = 0;
    cap.delete(); runs.delete(); ipgs.delete(); gaps.delete();
    uf_cnt = 0; idle_viol = 0; uf_txen_bad = 0;
    build_expect();
    while (1) begin
      @(negedge clk);
      if (txen) begin
        if (!prev_txen) begin
          if (runs.size() > 0) gaps.push_back(gap);
          gap = 0;
          runs.push_back(0);
          ipgs.push_back(0);
        end
        runs[runs.size()-1]++;
        cap.push_back(txd);
      end else begin
        if (txd !== 2'b00) idle_viol++;
        if (runs.size() > 0) begin
          gap++;
          if (busy) ipgs[ipgs.size()-1]++;
        end
      end
      if (uf_prev && txen) uf_txen_bad++;
      uf_prev = (underflow === 1'b1);
      if (underflow === 1'b1) uf_cnt++;
      prev_txen = txen;
      if (busy) seen = 1;
      if (xfer) idx++;
      if (idx == drop_at && (drop_at > 0 || seen)) done = 1;
      if (idx >= stream.size()) done = 1;
      if (done) begin
        axiiv = 0; axiid = 0; axiil = 0;
      end else begin
        axiiv = 1; axiid = stream[idx].d; axiil = stream[idx].l;
      end
      xfer = axiiv && axiir;
      if (done && seen && !busy) break;
      if (++cyc > 20000) begin check("stream_timeout", cyc, 0); break; end
    end
  endtask

  task automatic check_stream(input string tag);
    int errs = 0, n;
    check({tag, "_frames"}, runs.size(), exp_runs.size());
    n = (runs.size() < exp_runs.size()) ? runs.size() : exp_runs.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_len%0d", tag, i), runs[i], exp_runs[i]);
    check({tag, "_dibit_count"}, cap.size(), exp_d.size());
    n = (cap.size() < exp_d.size()) ? cap.size() : exp_d.size();
    for (int i = 0; i < n; i++) if (cap[i] !== exp_d[i]) errs++;
    check({tag, "_dibit_errs"}, errs, 0);
    check({tag, "_underflow"}, uf_cnt, exp_uf);
    check({tag, "_txen_after_uf"}, uf_txen_bad, 0);
    foreach (ipgs[i]) check($sformatf("%s_ipg%0d", tag, i), ipgs[i], IPG);
    check({tag, "_gap_count"}, gaps.size(), (exp_runs.size() > 0) ? exp_runs.size() - 1 : 0);
    foreach (gaps[i]) check($sformatf("%s_gap%0d", tag, i), gaps[i], IPG + 1);
    check({tag, "_txd_idle"}, idle_viol, 0);
  endtask

  typedef struct { int len; int mode; int drop; int exp_txen; int exp_uf; } vec_t;
  vec_t vt[7];

  initial begin
    int total, w;
    logic [31:0] fcs;
`ifdef ETHER_TX_PAD_EN
    vt[0] = '{9, 1, -1, 288, 0};
    vt[1] = '{1, 2, -1, 288, 0};
    vt[5] = '{59, 0, -1, 288, 0};
`else
    vt[0] = '{9, 1, -1, 84, 0};
    vt[1] = '{1, 2, -1, 52, 0};
    vt[5] = '{59, 0, -1, 284, 0};
`endif
    vt[2] = '{10, 0, 2, 40, 1};
    vt[3] = '{64, 0, -1, 304, 0};
    vt[4] = '{60, 0, -1, 288, 0};
    vt[6] = '{4, 0, 0, 32, 1};

    rst = 1; axiiv = 0; axiid = 0; axiil = 0; drop_at = -1;
    repeat (3) @(negedge clk);
    check("rst_txen", txen, 0);
    check("rst_txd", txd, 0);
    check("rst_axiir", axiir, 0);
    check("rst_busy", busy, 0);
    check("rst_underflow", underflow, 0);
    rst = 0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      stream.delete();
      push_frame(vt[i].len, vt[i].mode);
      drop_at = vt[i].drop;
      run_stream();
      check_stream($sformatf("vec%0d", i));
      total = 0;
      foreach (runs[k]) total += runs[k];
      check($sformatf("vec%0d_txen_total", i), total, vt[i].exp_txen);
      check($sformatf("vec%0d_uf_pulses", i), uf_cnt, vt[i].exp_uf);
`ifndef ETHER_TX_PAD_EN
      if (i == 0 && cap.size() >= 16) begin
        fcs = '0;
        for (int k = 0; k < 16; k++) fcs[2*k +: 2] = cap[cap.size() - 16 + k];
        check("fcs_123456789", fcs, 32'hCBF43926);
      end
`endif
    end

    // Two 64-byte frames with axiiv held high throughout.
    stream.delete();
    push_frame(64, 0);
    push_frame(64, 0);
    drop_at = -1;
    run_stream();
    check_stream("b2b");

    for (int r = 0; r < 8; r++) begin
      stream.delete();
      w = $urandom_range(1, 2);
      for (int f = 0; f < w; f++) push_frame($urandom_range(1, 70), 0);
      drop_at = -1;
      if (w == 1 && (r % 3) == 0 && stream.size() > 1) drop_at = $urandom_range(1, stream.size() - 1);
      run_stream();
      check_stream($sformatf("rnd%0d", r));
    end

    // Reset on the 5th DATA cycle, then restart straight after release.
    @(negedge clk);
    axiiv = 1; axiid = 8'h11; axiil = 0;
    w = 0;
    do begin @(negedge clk); w++; end while (!axiir && w < 100);
    check("rstseq_sfd_ready", axiir, 1);
    repeat (5) @(negedge clk);
    check("rstseq_pre_txen", txen, 1);
    rst = 1;
    @(negedge clk);
    check("rstseq_txen", txen, 0);
    check("rstseq_txd", txd, 0);
    check("rstseq_axiir", axiir, 0);
    check("rstseq_busy", busy, 0);
    check("rstseq_underflow", underflow, 0);
    rst = 0;
    @(negedge clk);
    check("rstseq_restart_txen", txen, 1);
    check("rstseq_restart_txd", txd, 2'b01);
    axiiv = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    stream.delete();
    push_frame(12, 0);
    drop_at = -1;
    run_stream();
    check_stream("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ether_tx.md
ETHER_TX -- requirements
Module: ether_tx

Interface
REQ-001 SHALL have parameter IPG_CYCLES, default 48, inter-packet gap length in clk cycles (96 bit times at 2 bits/cycle).
REQ-002 SHALL have parameter MIN_PAYLOAD, default 60, minimum bytes before FCS; used only when ETHER_TX_PAD_EN is defined.
REQ-003 SHALL have port clk  input  1  50 MHz RMII reference clock; the block's only clock.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port axiiv  input  1  upstream byte valid.
REQ-006 SHALL have port axiid  input  8  upstream byte (destination MAC first, no preamble, no FCS).
REQ-007 SHALL have port axiil  input  1  marks current byte as last of frame.
REQ-008 SHALL have port axiir  output  1  ready; a byte transfers on any cycle with axiiv & axiir.
REQ-009 SHALL have port txen  output  1  RMII TX_EN.
REQ-010 SHALL have port txd  output  2  RMII TXD dibit, txd[0] earlier bit.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port underflow  output  1  one-cycle pulse on aborted frame.

Function
REQ-013 SHALL implement states IDLE, PREAMBLE, DATA, PAD, FCS, IPG.
REQ-014 IDLE: txen=0, txd=00, axiir=0; axiiv=1 moves to PREAMBLE next cycle without consuming the byte.
REQ-015 PREAMBLE: 32 cycles, txen=1; txd=01 for cycles 0-30, txd=11 on cycle 31 (7x0x55 then SFD 0xD5, LSB first).
REQ-016 axiir SHALL be high exactly on the last PREAMBLE cycle and on the 4th dibit cycle of every DATA byte not flagged last; combinational from state/counter only, never from axiiv.
REQ-017 DATA: each accepted byte is sent over 4 cycles as axiid[1:0], [3:2], [5:4], [7:6]; first dibit of first byte on the cycle after the SFD 11 dibit; no gaps.
REQ-018 If axiiv=0 while axiir=1: underflow pulses that cycle, txen drops next cycle, go to IPG; no FCS sent.
REQ-019 After last byte's 4th dibit: go to FCS (or PAD, see REQ-027).
REQ-020 CRC-32 (poly 0x04C11DB7 reflected, init 0xFFFFFFFF) SHALL be updated 2 bits per cycle over every DATA/PAD dibit.
REQ-021 FCS: 16 cycles, txen=1, sends bitwise complement of CRC register, LSB first.
REQ-022 IPG: txen=0 for exactly IPG_CYCLES cycles, axiir=0, then IDLE; axiiv during IPG is ignored (held until IDLE).
REQ-023 Frame length counter SHALL be 11 bits and saturate at 2047; no length limit is enforced.
REQ-024 txen/txd SHALL be registered; txd=00 whenever txen=0.

Reset
REQ-025 rst SHALL force on the next edge: state IDLE, txen=0, txd=00, axiir=0, busy=0, underflow=0, CRC=0xFFFFFFFF, counters 0.
REQ-026 rst mid-frame SHALL truncate the frame with no FCS and no IPG; IDLE accepts a new frame the cycle after rst drops.

Configuration
REQ-027 With ETHER_TX_PAD_EN defined: if fewer than MIN_PAYLOAD bytes sent at axiil, PAD state emits 0x00 bytes (txd=00, txen=1) until MIN_PAYLOAD reached, CRC covering pad.
REQ-028 Without ETHER_TX_PAD_EN: PAD state absent, DATA goes directly to FCS regardless of length; MIN_PAYLOAD unused.

Verification
REQ-029 9-byte frame "123456789" (0x31..0x39), no pad -> 32 preamble cycles, 36 data cycles, FCS bytes on wire 26 39 F4 CB, then 48 cycles txen=0.
REQ-030 Single byte 0xA5 with ETHER_TX_PAD_EN -> txd 01,01,10,10 then 59x0x00 (236 cycles txd=00, txen=1), 16 FCS cycles; total txen high 32+240+16=288 cycles.
REQ-031 axiiv dropped at 3rd axiir of a 10-byte frame -> underflow one pulse, txen low next cycle, no FCS, busy high 48 more cycles.
REQ-032 rst asserted on 5th DATA cycle -> txen=0, axiir=0, busy=0 next cycle; new frame starts normally after rst release.
REQ-033 axiiv held high continuously with two back-to-back 64-byte frames -> exactly 48 txen-low cycles between frame 1's last FCS dibit and frame 2's first preamble dibit, plus 1 IDLE cycle.
